// File: rtl/power_mon_pkg.sv
// Shared definitions for the switching-activity monitors.
//   mon_state_e : monitor control states
//   cnt_w()     : bits needed to hold a count in 0..window
//   idx_w()     : bits needed to index `width` nets (minimum 1)
//   popcount()  : number of set bits in a vector of up to MaxWidth bits
package power_mon_pkg;

  // Widest monitored bus the popcount helper supports.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure,
    StDrain
  } mon_state_e;

  function automatic int unsigned cnt_w(input int unsigned window);
    return $clog2(window + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/toggle_cnt_bank.sv
// Bank of per-net toggle counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : zero every counter (wins over en_i)
//   en_i       : add toggle_i[i] to counter i
//   toggle_i   : per-net toggle flags for this sample
//   rd_idx_i   : counter selected onto count_o
//   count_o    : value of the selected counter (0 for out-of-range index)
module toggle_cnt_bank
  import power_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      en_i,
  input  logic [WIDTH-1:0]          toggle_i,
  input  logic [idx_w(WIDTH)-1:0]   rd_idx_i,
  output logic [CNT_W-1:0]          count_o
);

  localparam int unsigned IdxW = idx_w(WIDTH);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i) begin
        cnt_d[i] = '0;
      end else if (en_i) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(toggle_i[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Compare-based mux so a non-power-of-two WIDTH never indexes past the array.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rd_idx_i == IdxW'(i)) count_o = cnt_q[i];
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Switching-activity monitor: counts per-net transitions over WINDOW valid samples
// and streams the per-net counts out over a valid/ready handshake.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a measurement (only honoured in idle)
//   abort         : return to idle from any state, no results
//   sample_valid  : sample is meaningful this cycle
//   sample        : monitored net values
//   busy          : not idle
//   out_valid     : result beat available
//   out_ready     : consumer accepts beat
//   out_idx       : net index of current beat
//   out_count     : toggle count of net out_idx
//   out_last      : current beat is the final net
//   total         : sum of all toggles of the last measurement
//   done          : one-cycle pulse after the final beat handshake
// WIDTH must not exceed power_mon_pkg::MaxWidth.
module toggle_activity_monitor
  import power_mon_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned WINDOW = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                sample_valid,
  input  logic [WIDTH-1:0]                    sample,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [idx_w(WIDTH)-1:0]             out_idx,
  output logic [cnt_w(WINDOW)-1:0]            out_count,
  output logic                                out_last,
  output logic [$clog2(WIDTH*WINDOW+1)-1:0]   total,
  output logic                                done
);

  localparam int unsigned CntW = cnt_w(WINDOW);
  localparam int unsigned IdxW = idx_w(WIDTH);
  localparam int unsigned TotW = $clog2(WIDTH * WINDOW + 1);

  mon_state_e        state_q, state_d;
  logic [CntW-1:0]   win_q, win_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [TotW-1:0]   total_q, total_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;

  logic              start_acc;
  logic              arm_load;
  logic              count_en;
  logic              window_end;
  logic              beat_fire;
  logic              last_beat;
  logic [WIDTH-1:0]  toggle;
  logic [CntW-1:0]   bank_count;

  assign toggle     = sample ^ prev_q;
  assign start_acc  = (state_q == StIdle) && start && !abort;
  assign arm_load   = (state_q == StArm) && sample_valid && !abort;
  assign count_en   = (state_q == StMeasure) && sample_valid && !abort;
  assign window_end = count_en && (win_q == CntW'(WINDOW - 1));
  assign last_beat  = (idx_q == IdxW'(WIDTH - 1));
  assign beat_fire  = (state_q == StDrain) && out_ready && !abort;

  toggle_cnt_bank #(
    .WIDTH (WIDTH),
    .CNT_W (CntW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (start_acc),
    .en_i     (count_en),
    .toggle_i (toggle),
    .rd_idx_i (idx_q),
    .count_o  (bank_count)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start)                  state_d = StArm;
        StArm:     if (sample_valid)           state_d = StMeasure;
        StMeasure: if (window_end)             state_d = StDrain;
        StDrain:   if (out_ready && last_beat) state_d = StIdle;
        default:                               state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state: window counter, previous sample, total, beat index, done.
  always_comb begin
    win_d   = win_q;
    prev_d  = prev_q;
    total_d = total_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    if (start_acc) begin
      win_d   = '0;
      prev_d  = '0;
      total_d = '0;
      idx_d   = '0;
    end

    // First valid sample only establishes the reference value.
    if (arm_load) prev_d = sample;

    if (count_en) begin
      prev_d  = sample;
      total_d = total_q + TotW'(popcount(MaxWidth'(toggle)));
      win_d   = win_q + CntW'(1);
    end

    if (beat_fire) begin
      if (last_beat) begin
        idx_d  = '0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end

    if (abort) idx_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      prev_q  <= '0;
      total_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      prev_q  <= prev_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDrain);
    out_last  = out_valid && last_beat;
    out_count = out_valid ? bank_count : '0;
    out_idx   = idx_q;
    total     = total_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Self-checking bench for toggle_activity_monitor (WIDTH=5, WINDOW=4).
module tb_toggle_activity_monitor;

  localparam int unsigned W   = 5;
  localparam int unsigned WIN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sample_valid = 1'b0;
  logic [W-1:0] sample = '0;
  logic       out_ready = 1'b0;
  logic       busy, out_valid, out_last, done;
  logic [2:0] out_idx;
  logic [2:0] out_count;
  logic [4:0] total;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] s [WIN+1];
    int           cnt [W];
    int           tot;
  } vec_t;

  vec_t tbl [3];

  always #5 clk = ~clk;

  toggle_activity_monitor #(
    .WIDTH  (W),
    .WINDOW (WIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_count    (out_count),
    .out_last     (out_last),
    .total        (total),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_idx"},   out_idx, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_total"},     total, 0);
    check({tag, "_done"},      done, 0);
  endtask

  // One full measurement. gaps: random invalid cycles with garbage between samples.
  // mid_start: pulse start while measuring. stall_idx: hold ready low 3 cycles on that beat.
  // rst_idx: assert reset while that beat is presented. chain_start: start in the done cycle.
  task automatic run_measure(input logic [W-1:0] s [WIN+1], input int ec [W], input int et,
                             input bit gaps, input bit mid_start, input int stall_idx,
                             input int rst_idx, input bit chain_start);
    int beat;
    int cyc;
    int hold;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("no_valid_in_arm", out_valid, 0);
    for (int k = 0; k <= WIN; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sample_valid = 1'b0;
          sample = W'($urandom);
          @(negedge clk);
        end
      end
      sample_valid = 1'b1;
      sample = s[k];
      if (mid_start && k == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    sample_valid = 1'b0;
    sample = W'($urandom);

    beat = 0;
    cyc = 0;
    hold = 0;
    while (beat < W && cyc < 200) begin
      cyc++;
      check("beat_valid", out_valid, 1);
      check("beat_idx", out_idx, beat);
      check("beat_count", out_count, ec[beat]);
      check("beat_last", out_last, (beat == W - 1) ? 1 : 0);
      check("beat_busy", busy, 1);
      if (rst_idx == beat) begin
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        return;
      end
      if (beat == stall_idx && hold < 3) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_ready) beat++;
      @(negedge clk);
    end
    if (beat < W) check("drain_timeout", beat, W);
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", out_valid, 0);
    check("total", total, et);
    if (chain_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_single", done, 0);
    if (chain_start) check("start_in_done_accepted", busy, 1);
    else check("idle_after_done", busy, 0);
  endtask

  task automatic abort_seq();
    logic [W-1:0] pre [3];
    pre = '{5'h00, 5'h1F, 5'h00};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_valid = 1'b1;
      sample = pre[k];
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_no_valid", out_valid, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_stay_idle", busy, 0);
    end
  endtask

  initial begin
    logic [W-1:0] rs [WIN+1];
    int           rc [W];
    int           rt;

    tbl[0].s = '{5'h00, 5'h01, 5'h00, 5'h01, 5'h00};
    tbl[0].cnt = '{4, 0, 0, 0, 0};
    tbl[0].tot = 4;
    tbl[1].s = '{5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F};
    tbl[1].cnt = '{4, 4, 4, 4, 4};
    tbl[1].tot = 20;
    tbl[2].s = '{5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h0A};
    tbl[2].cnt = '{0, 0, 0, 0, 0};
    tbl[2].tot = 0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int t = 0; t < 3; t++) begin
      run_measure(tbl[t].s, tbl[t].cnt, tbl[t].tot, 1'b0, 1'b0, -1, -1, 1'b0);
    end

    // Invalid gaps with garbage data must not change results.
    run_measure(tbl[0].s, tbl[0].cnt, tbl[0].tot, 1'b1, 1'b0, -1, -1, 1'b0);

    // Backpressure on beat 2.
    run_measure(tbl[1].s, tbl[1].cnt, tbl[1].tot, 1'b0, 1'b0, 2, -1, 1'b0);

    // Abort then a fresh measurement, with an ignored start mid-measure.
    abort_seq();
    run_measure(tbl[0].s, tbl[0].cnt, tbl[0].tot, 1'b0, 1'b1, -1, -1, 1'b0);

    // Reset during drain at beat 3, then stay idle until start.
    run_measure(tbl[1].s, tbl[1].cnt, tbl[1].tot, 1'b0, 1'b0, -1, 3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      sample_valid = 1'b1;
      sample = (k % 2 == 0) ? 5'h1F : 5'h00;
      @(negedge clk);
      check("post_rst_idle", busy, 0);
      check("post_rst_no_valid", out_valid, 0);
    end
    sample_valid = 1'b0;

    // Start accepted in the done cycle; the next run's own start lands in ARM.
    run_measure(tbl[0].s, tbl[0].cnt, tbl[0].tot, 1'b0, 1'b0, -1, -1, 1'b1);
    run_measure(tbl[1].s, tbl[1].cnt, tbl[1].tot, 1'b0, 1'b0, -1, -1, 1'b0);

    // Random windows against a transition-count model.
    repeat (20) begin
      for (int k = 0; k <= WIN; k++) rs[k] = W'($urandom);
      rt = 0;
      for (int i = 0; i < W; i++) rc[i] = 0;
      for (int k = 1; k <= WIN; k++) begin
        for (int i = 0; i < W; i++) begin
          if (rs[k][i] != rs[k-1][i]) begin
            rc[i]++;
            rt++;
          end
        end
      end
      run_measure(rs, rc, rt, 1'($urandom_range(0, 1)), 1'b0, -1, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
